// File: rtl/julia_iter_if.sv
// julia_iter_if: pixel request / iteration-code result handshake bundle
// Ports (signals):
//   in_valid, in_ready          request handshake (upstream -> engine)
//   z0_re, z0_im, c_re, c_im    signed fixed-point request payload
//   out_valid, out_ready        result handshake (engine -> downstream)
//   value                       8-bit iteration code
// Modports: master = requester / result sink side, slave = engine side.
interface julia_iter_if #(parameter int WIDTH = 18);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] z0_re;
    logic signed [WIDTH-1:0] z0_im;
    logic signed [WIDTH-1:0] c_re;
    logic signed [WIDTH-1:0] c_im;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              value;
    modport master (output in_valid, z0_re, z0_im, c_re, c_im, out_ready,
                    input  in_ready, out_valid, value);
    modport slave  (input  in_valid, z0_re, z0_im, c_re, c_im, out_ready,
                    output in_ready, out_valid, value);
endinterface

// File: rtl/julia_iter.sv
// julia_iter: escape-time iteration of z <- z^2 + c for one pixel, one step per clock
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  julia_iter_if.slave: request (z0, c) in, 8-bit iteration code out
//        (0..MAX_ITER-1 = escape iteration, 255 = did not escape)
module julia_iter #(
    parameter int WIDTH    = 18,
    parameter int FRAC     = 14,
    parameter int MAX_ITER = 31
) (
    input logic         clk,
    input logic         rst,
    julia_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    localparam logic signed [2*WIDTH-1:0] FOUR = (2*WIDTH)'(4) << (2*FRAC);
    state_t                  state, state_d;
    logic signed [WIDTH-1:0] zr, zi, cr, ci, nr, ni;
    logic signed [2*WIDTH-1:0] rr, ii, ri;
    logic [7:0]              n, code;
    logic                    esc, last;
    assign rr   = zr * zr;
    assign ii   = zi * zi;
    assign ri   = zr * zi;
    // magnitude kept at full precision so the 4.0 threshold is exact
    assign esc  = (rr + ii) > FOUR;
    assign last = n == 8'(MAX_ITER - 1);
    assign nr   = WIDTH'((rr - ii) >>> FRAC) + cr;
    assign ni   = WIDTH'((ri <<< 1) >>> FRAC) + ci;
    assign bus.in_ready  = state == IDLE && !rst;
    assign bus.out_valid = state == DONE;
    assign bus.value     = code;
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_d;
    always_comb begin
        state_d = state;
        state_d = state == IDLE ? (bus.in_valid ? ITER : IDLE) :
                  state == ITER ? (esc || last ? DONE : ITER) :
                  (bus.out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk)
        if (rst) begin
            zr   <= '0;
            zi   <= '0;
            cr   <= '0;
            ci   <= '0;
            n    <= '0;
            code <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            zr <= bus.z0_re;
            zi <= bus.z0_im;
            cr <= bus.c_re;
            ci <= bus.c_im;
            n  <= '0;
        end else if (state == ITER) begin
            if (esc) code <= n;
            else if (last) code <= 8'd255;
            else begin
                zr <= nr;
                zi <= ni;
                n  <= n + 8'd1;
            end
        end
endmodule

// File: tb/tb_julia_iter.sv
// tb_julia_iter: scoreboard bench for julia_iter (expected codes queued at request time)
module tb_julia_iter;
    logic clk = 0;
    logic rst = 1;
    int   vectors = 0;
    int   errors  = 0;
    typedef struct {int v; int lat;} rec_t;
    rec_t sb[$];
    julia_iter_if #(.WIDTH(18)) bus();
    julia_iter dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic longint sx18(input longint x);
        return (x <<< 46) >>> 46;
    endfunction
    function automatic int model(input longint zr, input longint zi, input longint cr, input longint ci);
        longint rr, ii, tr, ti;
        for (int n = 0; n < 31; n++) begin
            rr = zr * zr;
            ii = zi * zi;
            if (rr + ii > (64'sd4 <<< 28)) return n;
            if (n == 30) return 255;
            tr = sx18(((rr - ii) >>> 14) + cr);
            ti = sx18(((2 * zr * zi) >>> 14) + ci);
            zr = tr;
            zi = ti;
        end
        return 255;
    endfunction
    task automatic send(input int zr, input int zi, input int cr, input int ci,
                        input int exp_v, input int hold, input bit scramble);
        int   cyc;
        rec_t r;
        logic [7:0] held;
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        chk("in_ready_idle", bus.in_ready, 1);
        bus.z0_re = 18'(zr);
        bus.z0_im = 18'(zi);
        bus.c_re = 18'(cr);
        bus.c_im = 18'(ci);
        bus.in_valid = 1;
        sb.push_back('{exp_v, exp_v == 255 ? 31 : exp_v + 1});
        @(posedge clk); #1;
        bus.in_valid = 0;
        if (scramble) begin
            bus.z0_re = 18'($urandom);
            bus.z0_im = 18'($urandom);
            bus.c_re = 18'($urandom);
            bus.c_im = 18'($urandom);
        end
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            chk("in_ready_busy", bus.in_ready, 0);
            @(posedge clk); #1; cyc++;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        r = sb.pop_front();
        chk("latency", cyc, r.lat);
        chk("value", bus.value, r.v);
        held = bus.value;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_value", bus.value, held);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1;
        @(posedge clk); #1;
        bus.out_ready = 0;
        chk("valid_drop", bus.out_valid, 0);
        chk("ready_back", bus.in_ready, 1);
    endtask
    initial begin
        int zr, zi, cr, ci;
        bus.in_valid = 0;
        bus.out_ready = 0;
        bus.z0_re = 0;
        bus.z0_im = 0;
        bus.c_re = 0;
        bus.c_im = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_value", bus.value, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        rst = 0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        send(0, 0, 0, 0, 255, 5, 0);
        send(40960, 0, 0, 0, 0, 0, 0);
        send(32768, 0, 0, 0, 1, 0, 0);
        send(24576, 0, 0, 0, 1, 1, 0);
        send(0, 0, 16384, 0, 3, 0, 0);
        send(0, 0, 0, 16384, 255, 2, 1);
        send(-40960, 0, 0, 0, 0, 0, 0);
        send(0, -32768, 0, 0, 1, 0, 0);
        // abort mid-iteration
        bus.z0_re = 0;
        bus.z0_im = 0;
        bus.c_re = 0;
        bus.c_im = 0;
        bus.in_valid = 1;
        @(posedge clk); #1;
        bus.in_valid = 0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst = 1;
        #1;
        chk("rst_mid_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        chk("rst_mid_out_valid", bus.out_valid, 0);
        rst = 0;
        #1;
        chk("rst_mid_ready_back", bus.in_ready, 1);
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) break;
        end
        chk("rst_no_result", bus.out_valid, 0);
        send(40960, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            zr = int'($urandom_range(0, 98304)) - 49152;
            zi = int'($urandom_range(0, 98304)) - 49152;
            cr = int'($urandom_range(0, 65534)) - 32767;
            ci = int'($urandom_range(0, 65534)) - 32767;
            send(zr, zi, cr, ci, model(zr, zi, cr, ci), int'($urandom_range(0, 2)), 1);
        end
        for (int i = 0; i < 6; i++) begin
            zr = int'($urandom_range(0, 16384)) - 8192;
            zi = int'($urandom_range(0, 16384)) - 8192;
            cr = int'($urandom_range(0, 8192)) - 4096;
            ci = int'($urandom_range(0, 8192)) - 4096;
            send(zr, zi, cr, ci, model(zr, zi, cr, ci), 0, 0);
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/julia_iter.md
Name: julia_iter

Overview:
- Escape-time engine for the Julia renderer: iterates z <- z^2 + c in signed fixed point for one pixel.
- Emits the 8-bit iteration code consumed by the colour lookup:
  - 0..MAX_ITER-1 = escape iteration.
  - 8'd255 = did not escape (in set).
- Sits between the pixel-coordinate generator (upstream) and framebuffer write (downstream), with valid/ready on both sides.
- One iteration per clock.

Parameters:
- WIDTH, 18, signed fixed-point width of all z/c components.
- FRAC, 14, fractional bits (1.0 = 2^FRAC = 16384).
- MAX_ITER, 31, iteration budget; must be <= 255.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  pixel request valid.
- in_ready  output  1  engine can accept a request.
- z0_re  input  WIDTH  initial z, real part, signed Q(WIDTH-FRAC).FRAC.
- z0_im  input  WIDTH  initial z, imaginary part.
- c_re  input  WIDTH  constant c, real part; caller guarantees |c_re|,|c_im| < 2.0.
- c_im  input  WIDTH  constant c, imaginary part.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- value  output  8  iteration code.

Behaviour:
- One clock; reset is synchronous and active-high; all state changes on rising clk.
- Reset values: state IDLE, out_valid 0, value 8'd0, n 0, internal z/c registers 0. in_ready is 0 while rst is high.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch z0 and c into z/c registers, clear n to 0, go to ITER.
  - ITER: in_ready=0. Each cycle compute mag = re*re + im*im at full 2*WIDTH precision (2*FRAC fractional bits, no truncation). Evaluate in this priority order:
    1. If mag > 4.0 (strictly greater; compare against 4 << (2*FRAC)): value <= n, go to DONE.
    2. Else if n == MAX_ITER-1: value <= 8'd255, go to DONE.
    3. Else: re <= ((re*re - im*im) >>> FRAC) + c_re; im <= ((2*re*im) >>> FRAC) + c_im; n <= n+1.
  - DONE: out_valid=1, value stable. On out_ready, out_valid <= 0 and go to IDLE. No same-cycle re-accept: in_ready stays low in DONE.
- Arithmetic:
  - Products are computed at 2*WIDTH bits; the arithmetic shift right by FRAC truncates toward -inf; results are truncated to WIDTH bits.
  - Because escape is tested before every update, |z| <= 2 whenever an update occurs, so the new components stay below 6.0 and no overflow occurs with the default WIDTH/FRAC.
- Latency: with acceptance at edge E0 and escape at count n, out_valid rises after edge E0+n+1.
  - Minimum is 1 cycle after acceptance (escape at n=0).
  - Maximum is MAX_ITER cycles (31 for the default, yielding 255).
- Backpressure: in DONE, value and out_valid hold indefinitely until out_ready; no new request is accepted meanwhile.
- Input values are sampled only at the acceptance edge; later changes on z0/c inputs are ignored.
- Reset mid-operation (ITER or DONE): abort, return to IDLE, out_valid 0; no partial result is emitted.
- Value range: escape values are always 0..MAX_ITER-1 (0..30 by default) or 255; never any other code.

Test Plan:
- c=(0,0), z0=(0,0) (all 0): after acceptance, out_valid rises exactly 31 cycles later with value=255; out_valid stays high through 5 cycles of out_ready=0, then drops one cycle after out_ready=1.
- c=(0,0), z0=(2.5,0) (z0_re=40960): value=0, out_valid 1 cycle after acceptance.
- Boundary:
  - c=(0,0), z0=(2.0,0) (32768): |z|^2=4.0 is not >4, so iterate once; z1=4.0, giving value=1.
  - z0=(1.5,0) (24576): 2.25 then 5.0625, giving value=1.
- c=(1.0,0) (16384), z0=(0,0): z sequence 0,1,2,5 gives value=3, latency 4 cycles.
- Complex path: c=(0,1.0), z0=(0,0): z sequence 0, i, -1+i, -i, -1+i, ... is periodic, giving value=255. Also check in_ready=0 throughout ITER/DONE and that z0/c changes mid-run are ignored.
- Assert rst for one cycle during ITER (e.g. n=10) with c=(0,0), z0=(0,0): out_valid stays 0, in_ready returns 1 the cycle after rst deasserts, and the next request (z0=2.5) yields value=0 normally.
